// File: rtl/alu16_sequencer_pkg.sv
// Shared definitions for the 16-bit ALU sequencer: flag indices, ALU opcodes,
// op16/state encodings and the per-step ALU request builders.
package alu16_sequencer_pkg;

  localparam int F_Z = 3;
  localparam int F_N = 2;
  localparam int F_H = 1;
  localparam int F_C = 0;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_ADC    = 5'd1;
  localparam logic [4:0] ALU_SUB    = 5'd2;
  localparam logic [4:0] ALU_SBC    = 5'd3;
  localparam logic [1:0] ALU_SIZE_8 = 2'd0;

  typedef enum logic [1:0] {
    ALU16_ADD    = 2'd0,
    ALU16_INC    = 2'd1,
    ALU16_DEC    = 2'd2,
    ALU16_ADDSPE = 2'd3
  } op16_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] data0;
    logic [7:0] data1;
    logic [4:0] op;
    logic [3:0] flags;
    logic [1:0] size;
  } alu_req_t;

  function automatic alu_req_t low_step(input op16_e op, input logic [15:0] a,
                                        input logic [15:0] b);
    alu_req_t req;
    req.size  = ALU_SIZE_8;
    req.flags = 4'b0000;
    req.data1 = a[7:0];
    case (op)
      ALU16_INC: begin req.op = ALU_ADD; req.data0 = 8'h01; end
      ALU16_DEC: begin req.op = ALU_SUB; req.data0 = 8'h01; end
      default:   begin req.op = ALU_ADD; req.data0 = b[7:0]; end
    endcase
    return req;
  endfunction

  // High byte chains the low-byte carry (or borrow) through the C flag input.
  function automatic alu_req_t high_step(input op16_e op, input logic [15:0] a,
                                         input logic [15:0] b, input logic c_lo);
    alu_req_t req;
    req.size  = ALU_SIZE_8;
    req.flags = {3'b000, c_lo};
    req.data1 = a[15:8];
    case (op)
      ALU16_ADD: begin req.op = ALU_ADC; req.data0 = b[15:8];    end
      ALU16_INC: begin req.op = ALU_ADC; req.data0 = 8'h00;      end
      ALU16_DEC: begin req.op = ALU_SBC; req.data0 = 8'h00;      end
      default:   begin req.op = ALU_ADC; req.data0 = {8{b[7]}};  end
    endcase
    return req;
  endfunction

endpackage

// File: rtl/alu16_sequencer_if.sv
// Bundle of the CPU-control, pass-through and ALU-side signals of the sequencer.
interface alu16_sequencer_if;
  logic        start;
  logic        flush;
  logic [1:0]  op16;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  flags_in;
  logic [7:0]  cpu_alu_data0;
  logic [7:0]  cpu_alu_data1;
  logic [4:0]  cpu_alu_op;
  logic [3:0]  cpu_alu_flags;
  logic [1:0]  cpu_alu_size;
  logic [7:0]  alu_data0;
  logic [7:0]  alu_data1;
  logic [4:0]  alu_op;
  logic [3:0]  alu_flags;
  logic [1:0]  alu_size;
  logic [7:0]  alu_result;
  logic [3:0]  alu_flags_res;
  logic        ready;
  logic        done;
  logic [15:0] result16;
  logic [3:0]  flags_out;

  modport slave (
    input  start, flush, op16, a_in, b_in, flags_in,
    input  cpu_alu_data0, cpu_alu_data1, cpu_alu_op, cpu_alu_flags, cpu_alu_size,
    input  alu_result, alu_flags_res,
    output alu_data0, alu_data1, alu_op, alu_flags, alu_size,
    output ready, done, result16, flags_out
  );

  modport master (
    output start, flush, op16, a_in, b_in, flags_in,
    output cpu_alu_data0, cpu_alu_data1, cpu_alu_op, cpu_alu_flags, cpu_alu_size,
    output alu_result, alu_flags_res,
    input  alu_data0, alu_data1, alu_op, alu_flags, alu_size,
    input  ready, done, result16, flags_out
  );
endinterface

// File: rtl/alu16_sequencer.sv
// Runs 16-bit ADD/INC/DEC/ADD SP,e as two byte steps on the shared 8-bit ALU;
// passes CPU ALU requests straight through whenever it is not sequencing.
module alu16_sequencer
  import alu16_sequencer_pkg::*;
(
  input logic              clock,
  input logic              reset_n,
  alu16_sequencer_if.slave bus
);

  state_e      r_state;
  state_e      w_next_state;
  op16_e       r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [3:0]  r_flags_cap;
  logic [7:0]  r_res_lo;
  logic        r_h_lo;
  logic        r_c_lo;
  logic [15:0] r_result16;
  logic [3:0]  r_flags_out;
  logic        w_accept;
  logic [3:0]  w_flags_comp;
  alu_req_t    w_cpu_req;
  alu_req_t    w_alu_req;

  assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_LOW;
      ST_LOW:  w_next_state = bus.flush ? ST_IDLE : ST_HIGH;
      ST_HIGH: w_next_state = bus.flush ? ST_IDLE : ST_DONE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_cpu_req = '{data0: bus.cpu_alu_data0, data1: bus.cpu_alu_data1,
                  op: bus.cpu_alu_op, flags: bus.cpu_alu_flags,
                  size: bus.cpu_alu_size};
    w_alu_req = w_cpu_req;
    if (r_state == ST_LOW)       w_alu_req = low_step(r_op, r_a, r_b);
    else if (r_state == ST_HIGH) w_alu_req = high_step(r_op, r_a, r_b, r_c_lo);
  end

  assign bus.alu_data0 = w_alu_req.data0;
  assign bus.alu_data1 = w_alu_req.data1;
  assign bus.alu_op    = w_alu_req.op;
  assign bus.alu_flags = w_alu_req.flags;
  assign bus.alu_size  = w_alu_req.size;
  assign bus.ready     = (r_state == ST_IDLE);
  assign bus.done      = (r_state == ST_DONE) && !bus.flush;
  assign bus.result16  = r_result16;
  assign bus.flags_out = r_flags_out;

  always_comb begin
    w_flags_comp = r_flags_cap;
    case (r_op)
      ALU16_ADD: begin
        w_flags_comp[F_N] = 1'b0;
        w_flags_comp[F_H] = bus.alu_flags_res[F_H];
        w_flags_comp[F_C] = bus.alu_flags_res[F_C];
      end
      ALU16_ADDSPE: begin
        w_flags_comp[F_Z] = 1'b0;
        w_flags_comp[F_N] = 1'b0;
        w_flags_comp[F_H] = r_h_lo;
        w_flags_comp[F_C] = r_c_lo;
      end
      default: w_flags_comp = r_flags_cap;
    endcase
  end

  // Flushed steps never write, so an aborted op leaves the last result visible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op        <= ALU16_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_flags_cap <= '0;
      r_res_lo    <= '0;
      r_h_lo      <= 1'b0;
      r_c_lo      <= 1'b0;
      r_result16  <= '0;
      r_flags_out <= '0;
    end else begin
      if (w_accept) begin
        r_op        <= op16_e'(bus.op16);
        r_a         <= bus.a_in;
        r_b         <= bus.b_in;
        r_flags_cap <= bus.flags_in;
      end
      if (r_state == ST_LOW && !bus.flush) begin
        r_res_lo <= bus.alu_result;
        r_h_lo   <= bus.alu_flags_res[F_H];
        r_c_lo   <= bus.alu_flags_res[F_C];
      end
      if (r_state == ST_HIGH && !bus.flush) begin
        r_result16  <= {bus.alu_result, r_res_lo};
        r_flags_out <= w_flags_comp;
      end
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Self-checking bench: byte-level ALU model as the environment, 16-bit
// arithmetic reference model for expected results and flags.
module tb_alu16_sequencer;
  import alu16_sequencer_pkg::*;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  alu16_sequencer_if bus ();

  alu16_sequencer dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment: the shared 8-bit ALU (data1 op data0 with optional carry-in).
  logic [8:0] m_full;
  logic [4:0] m_half;
  logic       m_cin;
  logic       m_sub;
  always_comb begin
    m_cin  = (bus.alu_op == ALU_ADC || bus.alu_op == ALU_SBC) ? bus.alu_flags[F_C] : 1'b0;
    m_sub  = (bus.alu_op == ALU_SUB || bus.alu_op == ALU_SBC);
    if (m_sub) begin
      m_full = {1'b0, bus.alu_data1} - {1'b0, bus.alu_data0} - {8'b0, m_cin};
      m_half = {1'b0, bus.alu_data1[3:0]} - {1'b0, bus.alu_data0[3:0]} - {4'b0, m_cin};
    end else begin
      m_full = {1'b0, bus.alu_data1} + {1'b0, bus.alu_data0} + {8'b0, m_cin};
      m_half = {1'b0, bus.alu_data1[3:0]} + {1'b0, bus.alu_data0[3:0]} + {4'b0, m_cin};
    end
    bus.alu_result    = m_full[7:0];
    bus.alu_flags_res = {(m_full[7:0] == 8'h00), m_sub, m_half[4], m_full[8]};
  end

  // Reference: {result16, ZNHC} from whole-word arithmetic.
  function automatic logic [19:0] ref_op(input logic [1:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] f);
    int unsigned ai, bi, e, se, sum;
    logic [15:0] r;
    logic [3:0]  fo;
    ai = a; bi = b; e = b[7:0];
    se = b[7] ? (e | 32'hFF00) : e;
    case (op)
      2'd0: begin
        sum = ai + bi;
        r = sum[15:0];
        fo = {f[3], 1'b0, ((ai & 32'hFFF) + (bi & 32'hFFF)) > 32'hFFF, sum > 32'hFFFF};
      end
      2'd1: begin sum = ai + 1; r = sum[15:0]; fo = f; end
      2'd2: begin sum = ai + 32'hFFFF; r = sum[15:0]; fo = f; end
      default: begin
        sum = ai + se;
        r = sum[15:0];
        fo = {2'b00, ((ai & 32'hF) + (e & 32'hF)) > 32'hF, ((ai & 32'hFF) + e) > 32'hFF};
      end
    endcase
    return {r, fo};
  endfunction

  task automatic randomize_cpu();
    bus.cpu_alu_data0 = 8'($urandom);
    bus.cpu_alu_data1 = 8'($urandom);
    bus.cpu_alu_op    = 5'($urandom);
    bus.cpu_alu_flags = 4'($urandom);
    bus.cpu_alu_size  = 2'($urandom);
  endtask

  // Issues one op from IDLE; reports done latency (edges after accept, -1 if
  // none within the budget), the result at done, and state one edge later.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f, output int lat, output logic [15:0] res,
                        output logic [3:0] flg, output logic rdy_after,
                        output logic done_after);
    bus.op16 = op; bus.a_in = a; bus.b_in = b; bus.flags_in = f;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    lat = -1; res = '0; flg = '0;
    for (int n = 0; n < 8; n++) begin
      if (bus.done) begin
        lat = n; res = bus.result16; flg = bus.flags_out;
        break;
      end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    rdy_after = bus.ready;
    done_after = bus.done;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.ready); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.result16 !== 16'h0000) $display("FAIL reset_result got %h want 0000", bus.result16); else n_pass++;
    n_checks++; if (bus.flags_out !== 4'h0) $display("FAIL reset_flags got %b want 0000", bus.flags_out); else n_pass++;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 8; i++) begin
      randomize_cpu();
      #1;
      n_checks++;
      if ({bus.alu_data0, bus.alu_data1, bus.alu_op, bus.alu_flags, bus.alu_size} !==
          {bus.cpu_alu_data0, bus.cpu_alu_data1, bus.cpu_alu_op, bus.cpu_alu_flags, bus.cpu_alu_size})
        $display("FAIL passthrough[%0d] got %h/%h/%h/%h/%h want %h/%h/%h/%h/%h", i,
                 bus.alu_data0, bus.alu_data1, bus.alu_op, bus.alu_flags, bus.alu_size,
                 bus.cpu_alu_data0, bus.cpu_alu_data1, bus.cpu_alu_op, bus.cpu_alu_flags,
                 bus.cpu_alu_size);
      else n_pass++;
      @(posedge clock); #1;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    logic [15:0] r;
    logic [3:0]  fo;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[6];
    int lat; logic [15:0] res; logic [3:0] flg; logic rdy, dn;
    vecs[0] = '{op: 2'd0, a: 16'h8FFF, b: 16'h0001, f: 4'b1000, r: 16'h9000, fo: 4'b1010};
    vecs[1] = '{op: 2'd0, a: 16'hFFFF, b: 16'h0001, f: 4'b0000, r: 16'h0000, fo: 4'b0011};
    vecs[2] = '{op: 2'd1, a: 16'h00FF, b: 16'h1234, f: 4'b0101, r: 16'h0100, fo: 4'b0101};
    vecs[3] = '{op: 2'd2, a: 16'h0000, b: 16'hBEEF, f: 4'b1010, r: 16'hFFFF, fo: 4'b1010};
    vecs[4] = '{op: 2'd3, a: 16'hFFF8, b: 16'h0008, f: 4'b1111, r: 16'h0000, fo: 4'b0011};
    vecs[5] = '{op: 2'd3, a: 16'h0005, b: 16'h00FE, f: 4'b1100, r: 16'h0003, fo: 4'b0011};
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].f, lat, res, flg, rdy, dn);
      n_checks++; if (lat !== 2) $display("FAIL dir[%0d]_latency got %0d want 2", i, lat); else n_pass++;
      n_checks++; if (res !== vecs[i].r) $display("FAIL dir[%0d]_result got %h want %h", i, res, vecs[i].r); else n_pass++;
      n_checks++; if (flg !== vecs[i].fo) $display("FAIL dir[%0d]_flags got %b want %b", i, flg, vecs[i].fo); else n_pass++;
      n_checks++; if (rdy !== 1'b1) $display("FAIL dir[%0d]_ready_after got %b want 1", i, rdy); else n_pass++;
      n_checks++; if (dn !== 1'b0) $display("FAIL dir[%0d]_single_done got %b want 0", i, dn); else n_pass++;
    end
  endtask

  task automatic test_random();
    int lat; logic [15:0] res, a, b; logic [3:0] flg, f; logic [1:0] op; logic rdy, dn;
    logic [19:0] exp;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3)); a = 16'($urandom); b = 16'($urandom); f = 4'($urandom);
      randomize_cpu();
      exp = ref_op(op, a, b, f);
      run_op(op, a, b, f, lat, res, flg, rdy, dn);
      n_checks++; if (lat !== 2) $display("FAIL rnd[%0d]_latency got %0d want 2", i, lat); else n_pass++;
      n_checks++; if (res !== exp[19:4]) $display("FAIL rnd[%0d]_result op=%0d a=%h b=%h got %h want %h", i, op, a, b, res, exp[19:4]); else n_pass++;
      n_checks++; if (flg !== exp[3:0]) $display("FAIL rnd[%0d]_flags op=%0d a=%h b=%h f=%b got %b want %b", i, op, a, b, f, flg, exp[3:0]); else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    logic [19:0] exp; int dones; logic [15:0] res;
    bus.op16 = 2'd0; bus.a_in = 16'h1234; bus.b_in = 16'h0F0F; bus.flags_in = 4'b0000;
    exp = ref_op(2'd0, 16'h1234, 16'h0F0F, 4'b0000);
    bus.start = 1'b1;
    @(posedge clock); #1;
    n_checks++; if (bus.ready !== 1'b0) $display("FAIL busy_ready got %b want 0", bus.ready); else n_pass++;
    bus.op16 = 2'd2; bus.a_in = 16'h7777; bus.b_in = 16'h1111;
    @(posedge clock); #1;
    bus.start = 1'b0;
    randomize_cpu();
    dones = 0; res = '0;
    for (int n = 0; n < 6; n++) begin
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          res = bus.result16;
          n_checks++;
          if (bus.alu_op !== bus.cpu_alu_op || bus.alu_data0 !== bus.cpu_alu_data0)
            $display("FAIL done_passthrough got %h/%h want %h/%h", bus.alu_op, bus.alu_data0,
                     bus.cpu_alu_op, bus.cpu_alu_data0);
          else n_pass++;
        end
      end
      @(posedge clock); #1;
    end
    n_checks++; if (dones !== 1) $display("FAIL busy_done_count got %0d want 1", dones); else n_pass++;
    n_checks++; if (res !== exp[19:4]) $display("FAIL busy_result got %h want %h", res, exp[19:4]); else n_pass++;
  endtask

  task automatic test_flush();
    int lat, dones; logic [15:0] res; logic [3:0] flg; logic rdy, dn; logic [19:0] exp;
    run_op(2'd0, 16'h0101, 16'h0202, 4'b1000, lat, res, flg, rdy, dn);
    // Flush while in HIGH: no done, previous result kept.
    bus.op16 = 2'd1; bus.a_in = 16'hAAAA; bus.flags_in = 4'b0110; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #1;
    bus.flush = 1'b1;
    @(posedge clock); #1;
    bus.flush = 1'b0;
    n_checks++; if (bus.ready !== 1'b1) $display("FAIL flush_high_ready got %b want 1", bus.ready); else n_pass++;
    dones = 0;
    for (int n = 0; n < 5; n++) begin
      if (bus.done) dones++;
      @(posedge clock); #1;
    end
    n_checks++; if (dones !== 0) $display("FAIL flush_high_done got %0d want 0", dones); else n_pass++;
    n_checks++; if (bus.result16 !== 16'h0303) $display("FAIL flush_high_result got %h want 0303", bus.result16); else n_pass++;
    n_checks++; if (bus.flags_out !== 4'b1000) $display("FAIL flush_high_flags got %b want 1000", bus.flags_out); else n_pass++;
    // Flush while in DONE: pulse suppressed, completed result stays.
    exp = ref_op(2'd3, 16'h1000, 16'h00F0, 4'b0000);
    bus.op16 = 2'd3; bus.a_in = 16'h1000; bus.b_in = 16'h00F0; bus.flags_in = 4'b0000; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    bus.flush = 1'b1;
    #1;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL flush_done_pulse got %b want 0", bus.done); else n_pass++;
    @(posedge clock); #1;
    bus.flush = 1'b0;
    n_checks++; if (bus.ready !== 1'b1) $display("FAIL flush_done_ready got %b want 1", bus.ready); else n_pass++;
    n_checks++; if (bus.result16 !== exp[19:4]) $display("FAIL flush_done_result got %h want %h", bus.result16, exp[19:4]); else n_pass++;
    // Flush beats start in IDLE.
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    n_checks++; if (bus.ready !== 1'b1) $display("FAIL flush_idle_ready got %b want 1", bus.ready); else n_pass++;
    dones = 0;
    for (int n = 0; n < 5; n++) begin
      if (bus.done) dones++;
      @(posedge clock); #1;
    end
    n_checks++; if (dones !== 0) $display("FAIL flush_idle_done got %0d want 0", dones); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] res; logic [3:0] flg; logic rdy, dn; logic [19:0] exp;
    bus.op16 = 2'd0; bus.a_in = 16'h4321; bus.b_in = 16'h1111; bus.flags_in = 4'b1111; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.ready !== 1'b1) $display("FAIL midreset_ready got %b want 1", bus.ready); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL midreset_done got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.result16 !== 16'h0000) $display("FAIL midreset_result got %h want 0000", bus.result16); else n_pass++;
    n_checks++; if (bus.flags_out !== 4'h0) $display("FAIL midreset_flags got %b want 0000", bus.flags_out); else n_pass++;
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp = ref_op(2'd2, 16'h8000, 16'h0000, 4'b0100);
    run_op(2'd2, 16'h8000, 16'h0000, 4'b0100, lat, res, flg, rdy, dn);
    n_checks++; if (lat !== 2) $display("FAIL postreset_latency got %0d want 2", lat); else n_pass++;
    n_checks++; if (res !== exp[19:4]) $display("FAIL postreset_result got %h want %h", res, exp[19:4]); else n_pass++;
    n_checks++; if (flg !== exp[3:0]) $display("FAIL postreset_flags got %b want %b", flg, exp[3:0]); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op16 = '0;
    bus.a_in = '0; bus.b_in = '0; bus.flags_in = '0;
    randomize_cpu();
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clock); #1;
    test_passthrough();
    test_directed();
    test_random();
    test_start_ignored();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
